// File: rtl/pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack -- hardware return-address stack for the DSP core program counter.
//
// Sits directly upstream of the PC register. A CALL pushes the return address
// and a RET pops it. `top` is muxed into the PC register's d input. `enable`
// tracks the PC register enable, so the stack and the PC stall together.
//
// Parameters:
//   W      address width (matches the PC register width)
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous, active-low reset (clears pointer, count, flags)
//   enable     advance; when low all state holds and push/pop are ignored
//   push       push push_addr (CALL)
//   pop        pop the top entry (RET)
//   push_addr  return address to push
//   clr_err    clears the sticky error flags (honoured even when enable = 0)
//   top        current top-of-stack, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop attempted while empty
//
// Build option:
//   PC_STACK_CIRC_EN  when defined, a push while full overwrites the oldest
//                     entry, so the newest DEPTH addresses stay poppable.
//                     When undefined, a push while full is dropped.
//
// All outputs depend only on registered state.
// -----------------------------------------------------------------------------
module pc_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_addr,
    input  logic          clr_err,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    // Storage is deliberately not reset. The contents are only observable
    // through entries counted as valid.
    logic [W-1:0]  mem_reg [DEPTH];

    logic [AW-1:0] wp_reg, wp_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          ovf_set;
    logic          unf_set;

    logic          empty_int;
    logic          full_int;
    logic [AW-1:0] wp_dec;

    assign empty_int = (count_reg == '0);
    assign full_int  = (count_reg == COUNT_MAX);
    assign wp_dec    = wp_reg - 1'b1;   // wraps modulo DEPTH

    // -------------------------------------------------------------------------
    // Next-state decode
    // -------------------------------------------------------------------------
    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = wp_reg;
        wp_next    = wp_reg;
        count_next = count_reg;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;

        if (enable) begin
            if (push && pop) begin
                if (empty_int) begin
                    // Nothing to replace, so this behaves as a plain push.
                    // An empty stack is never full because DEPTH >= 2.
                    wr_en      = 1'b1;
                    wr_addr    = wp_reg;
                    wp_next    = wp_reg + 1'b1;
                    count_next = count_reg + 1'b1;
                    unf_set    = 1'b1;
                end else begin
                    // Tail-call: replace the top entry in place.
                    wr_en   = 1'b1;
                    wr_addr = wp_dec;
                end
            end else if (push) begin
                if (!full_int) begin
                    wr_en      = 1'b1;
                    wr_addr    = wp_reg;
                    wp_next    = wp_reg + 1'b1;
                    count_next = count_reg + 1'b1;
                end else begin
                    ovf_set = 1'b1;
`ifdef PC_STACK_CIRC_EN
                    // When full, wp points at the oldest entry. Overwrite it
                    // and advance; count stays saturated at DEPTH.
                    wr_en   = 1'b1;
                    wr_addr = wp_reg;
                    wp_next = wp_reg + 1'b1;
`else
                    // The push is dropped and storage is left intact.
`endif
                end
            end else if (pop) begin
                if (!empty_int) begin
                    wp_next    = wp_dec;
                    count_next = count_reg - 1'b1;
                end else begin
                    unf_set = 1'b1;
                end
            end
        end

        // A new error in the same cycle as clr_err wins. unf_set and ovf_set
        // are only raised while enabled, but clr_err acts at any time.
        overflow_next  = ovf_set | (overflow_reg  & ~clr_err);
        underflow_next = unf_set | (underflow_reg & ~clr_err);
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp_reg        <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wp_reg        <= wp_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // -------------------------------------------------------------------------
    // Storage. A write coinciding with reset is discarded.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem_reg[wr_addr] <= push_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign top       = empty_int ? '0 : mem_reg[wp_dec];
    assign count     = count_reg;
    assign empty     = empty_int;
    assign full      = full_int;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_pc_stack.sv
// -----------------------------------------------------------------------------
// tb_pc_stack -- directed self-checking bench for pc_stack (W = 32, DEPTH = 8).
//
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
// Each scenario is a task with its own inline comparisons.
// -----------------------------------------------------------------------------
module tb_pc_stack;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          push;
    logic          pop;
    logic [W-1:0]  push_addr;
    logic          clr_err;
    logic [W-1:0]  top;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    pc_stack #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .clr_err   (clr_err),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic idle();
        enable    = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        clr_err   = 1'b0;
        push_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t en=%0b push=%0b pop=%0b addr=0x%0h clr=%0b -> top=0x%0h count=%0d empty=%0b full=%0b ovf=%0b unf=%0b",
                 $time, enable, push, pop, push_addr, clr_err, top, count, empty, full, overflow, underflow);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b1;
        pop = 1'b1; step();                               // underflow set
        pop = 1'b0; push = 1'b1; push_addr = 32'h11; step();
        push_addr = 32'h22; step();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL reset_pre_count got=%0d exp=2", count); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL reset_pre_unf got=%0b exp=1", underflow); end
        // Reset held for 2 cycles with a push still asserted.
        reset_n = 1'b0; push_addr = 32'h33;
        step(); step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if (top !== 32'h0) begin errors++; $display("FAIL reset_top got=0x%0h exp=0x0", top); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got=%0b exp=0", underflow); end
        reset_n = 1'b1;
        idle();
    endtask

    task automatic test_lifo();
        do_reset();
        push = 1'b1;
        push_addr = 32'h100; step();
        checks++; if (top !== 32'h100) begin errors++; $display("FAIL lifo_push1_top got=0x%0h exp=0x100", top); end
        push_addr = 32'h200; step();
        push_addr = 32'h300; step();
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL lifo_count got=%0d exp=3", count); end
        push = 1'b0; pop = 1'b1;
        checks++; if (top !== 32'h300) begin errors++; $display("FAIL lifo_pop1 got=0x%0h exp=0x300", top); end
        step();
        checks++; if (top !== 32'h200) begin errors++; $display("FAIL lifo_pop2 got=0x%0h exp=0x200", top); end
        step();
        checks++; if (top !== 32'h100) begin errors++; $display("FAIL lifo_pop3 got=0x%0h exp=0x100", top); end
        step();
        pop = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lifo_empty got=%0b exp=1", empty); end
        checks++; if (top !== 32'h0) begin errors++; $display("FAIL lifo_empty_top got=0x%0h exp=0x0", top); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL lifo_unf got=%0b exp=0", underflow); end
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        push = 1'b1; push_addr = 32'h10; step();
        enable = 1'b0; push_addr = 32'h20; step();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL stall_count got=%0d exp=1", count); end
        checks++; if (top !== 32'h10) begin errors++; $display("FAIL stall_top got=0x%0h exp=0x10", top); end
        pop = 1'b1; step();                               // still stalled
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL stall2_count got=%0d exp=1", count); end
        pop = 1'b0; enable = 1'b1; step();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL stall_release_count got=%0d exp=2", count); end
        checks++; if (top !== 32'h20) begin errors++; $display("FAIL stall_release_top got=0x%0h exp=0x20", top); end
        idle();
    endtask

    task automatic test_tail_call();
        do_reset();
        push = 1'b1; push_addr = 32'h40; step();
        pop = 1'b1; push_addr = 32'h44; step();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL tail_count got=%0d exp=1", count); end
        checks++; if (top !== 32'h44) begin errors++; $display("FAIL tail_top got=0x%0h exp=0x44", top); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL tail_unf got=%0b exp=0", underflow); end
        push = 1'b0; step();                              // pop -> empty
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL tail_empty got=%0b exp=1", empty); end
        push = 1'b1; push_addr = 32'h50; step();          // push+pop on empty
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL tail_empty_count got=%0d exp=1", count); end
        checks++; if (top !== 32'h50) begin errors++; $display("FAIL tail_empty_top got=0x%0h exp=0x50", top); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL tail_empty_unf got=%0b exp=1", underflow); end
        idle();
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp_top;
        do_reset();
        push = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            push_addr = W'(i);
            step();
        end
        push = 1'b0;
`ifdef PC_STACK_CIRC_EN
        exp_top = 32'd9;
`else
        exp_top = 32'd8;
`endif
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%0b exp=1", full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        checks++; if (top !== exp_top) begin errors++; $display("FAIL ovf_top got=0x%0h exp=0x%0h", top, exp_top); end
        pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (top !== exp_top) begin errors++; $display("FAIL ovf_pop%0d got=0x%0h exp=0x%0h", i, top, exp_top); end
            step();
            exp_top = exp_top - 32'd1;
        end
        pop = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained_empty got=%0b exp=1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
        idle();
    endtask

    task automatic test_err_clear();
        do_reset();
        pop = 1'b1; step();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clr_set_unf got=%0b exp=1", underflow); end
        pop = 1'b0; clr_err = 1'b1; step();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clr_alone got=%0b exp=0", underflow); end
        pop = 1'b1; step();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clr_with_err got=%0b exp=1", underflow); end
        pop = 1'b0; enable = 1'b0; step();                // clear honoured while stalled
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clr_stalled got=%0b exp=0", underflow); end
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        step();
        step();
        test_reset();
        test_lifo();
        test_stall();
        test_tail_call();
        test_overflow();
        test_err_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
